// File: rtl/ss_seq_if.sv
// ss_seq_if: mapper save-state bus plus snapshot buffer request bus.
// master (sequencer) drives ss_act/ss_we/ss_addr/ss_wdat and mem_addr/mem_wr/mem_rd/mem_wdat;
// slave (mapper + buffer) returns ss_rdat, mem_rdat and mem_ack.
interface ss_seq_if;
    logic       ss_act;
    logic       ss_we;
    logic [7:0] ss_addr;
    logic [7:0] ss_wdat;
    logic [7:0] ss_rdat;
    logic [7:0] mem_addr;
    logic       mem_wr;
    logic       mem_rd;
    logic [7:0] mem_wdat;
    logic [7:0] mem_rdat;
    logic       mem_ack;
    modport master (
        output ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_wr, mem_rd, mem_wdat,
        input  ss_rdat, mem_rdat, mem_ack
    );
    modport slave (
        input  ss_act, ss_we, ss_addr, ss_wdat, mem_addr, mem_wr, mem_rd, mem_wdat,
        output ss_rdat, mem_rdat, mem_ack
    );
endinterface

// File: rtl/ss_seq.sv
// ss_seq: save-state sequencer streaming mapper registers to/from a snapshot buffer.
// Ports: m2 clock, map_rst sync active-high reset, cmd_save/cmd_load command pulses,
// busy/done/err status, bus = save-state + buffer interface (master side).
module ss_seq #(
    parameter int          LAST_REG  = 13,
    parameter int          IDX_ADDR  = 127,
    parameter logic [15:0] SKIP_MASK = 16'h0200
) (
    input  logic     m2,
    input  logic     map_rst,
    input  logic     cmd_save,
    input  logic     cmd_load,
    output logic     busy,
    output logic     done,
    output logic     err,
    ss_seq_if.master bus
);
    typedef enum logic [2:0] {IDLE, S_ADDR, S_MEM, L_HDR, L_CHK, L_MEM, L_WR, DONE} state_t;
    state_t     state, state_n;
    logic [4:0] idx, idx_n, nxt;
    logic       hdr, hdr_n, nv, err_n;
    logic [7:0] maddr, maddr_n, mwdat, mwdat_n, swdat, swdat_n, hbyte, hbyte_n;
    // Next register to visit: first unskipped index after idx, or the first one at all
    // while the header entry is current. nv=0 means the walk is finished.
    always_comb begin
        nxt = '0;
        nv  = 1'b0;
        for (int n = LAST_REG; n >= 0; n--)
            if (!SKIP_MASK[n] && (hdr || n > int'(idx))) begin
                nxt = 5'(n);
                nv  = 1'b1;
            end
    end
    always_ff @(posedge m2) begin
        if (map_rst) begin
            state <= IDLE;
            idx   <= '0;
            hdr   <= 1'b0;
            err   <= 1'b0;
            maddr <= '0;
            mwdat <= '0;
            swdat <= '0;
            hbyte <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            hdr   <= hdr_n;
            err   <= err_n;
            maddr <= maddr_n;
            mwdat <= mwdat_n;
            swdat <= swdat_n;
            hbyte <= hbyte_n;
        end
    end
    always_comb begin
        state_n = state;
        idx_n   = idx;
        hdr_n   = hdr;
        err_n   = err;
        maddr_n = maddr;
        mwdat_n = mwdat;
        swdat_n = swdat;
        hbyte_n = hbyte;
        case (state)
            IDLE: begin
                if (cmd_save || cmd_load) begin
                    state_n = cmd_save ? S_ADDR : L_HDR;
                    idx_n   = '0;
                    hdr_n   = 1'b1;
                    err_n   = 1'b0;
                    maddr_n = '0;
                end
            end
            S_ADDR: begin
                state_n = S_MEM;
                mwdat_n = bus.ss_rdat;
                maddr_n = hdr ? 8'd0 : 8'(idx) + 8'd1;
            end
            S_MEM: begin
                if (bus.mem_ack) begin
                    state_n = nv ? S_ADDR : DONE;
                    idx_n   = nv ? nxt : idx;
                    hdr_n   = 1'b0;
                end
            end
            L_HDR: begin
                if (bus.mem_ack) begin
                    state_n = L_CHK;
                    hbyte_n = bus.mem_rdat;
                end
            end
            L_CHK: begin
                if (bus.ss_rdat != hbyte) begin
                    err_n   = 1'b1;
                    state_n = DONE;
                end else begin
                    state_n = nv ? L_MEM : DONE;
                    idx_n   = nv ? nxt : idx;
                    hdr_n   = 1'b0;
                    maddr_n = 8'(nxt) + 8'd1;
                end
            end
            L_MEM: begin
                if (bus.mem_ack) begin
                    state_n = L_WR;
                    swdat_n = bus.mem_rdat;
                end
            end
            L_WR: begin
                state_n = nv ? L_MEM : DONE;
                idx_n   = nv ? nxt : idx;
                maddr_n = 8'(nxt) + 8'd1;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign busy         = state != IDLE && state != DONE;
    assign done         = state == DONE;
    assign bus.ss_act   = busy;
    assign bus.ss_we    = state == L_WR;
    // Address is held for the whole sampling/write cycle since it depends only on state.
    assign bus.ss_addr  = (state == L_CHK || (state == S_ADDR && hdr)) ? 8'(IDX_ADDR) :
                          (state == S_ADDR || state == L_WR) ? 8'(idx) : 8'd0;
    assign bus.ss_wdat  = swdat;
    assign bus.mem_addr = maddr;
    assign bus.mem_wdat = mwdat;
    assign bus.mem_wr   = state == S_MEM;
    assign bus.mem_rd   = state == L_HDR || state == L_MEM;
endmodule

// File: tb/tb_ss_seq.sv
// tb_ss_seq: directed table-driven bench for ss_seq with mapper and buffer models.
module tb_ss_seq;
    logic m2 = 1'b0, map_rst = 1'b1, cmd_save = 1'b0, cmd_load = 1'b0;
    logic busy, done, err;
    ss_seq_if bus();
    ss_seq dut (
        .m2(m2), .map_rst(map_rst), .cmd_save(cmd_save), .cmd_load(cmd_load),
        .busy(busy), .done(done), .err(err), .bus(bus)
    );
    always #5 m2 = ~m2;
    int checks = 0, errors = 0;
    logic [7:0] map_idx = 8'h31;
    logic [7:0] mem [0:255];
    logic [7:0] saved [0:255];
    int dly = 0, wcnt = 0;
    int we_cnt = 0, wr_cnt = 0, bad_we = 0, viol = 0, unstable = 0;
    logic [15:0] we_mask = '0;
    logic pend_q = 1'b0;
    logic [7:0] pa = '0, pd = '0;
    assign bus.ss_rdat  = (bus.ss_addr == 8'd127) ? map_idx : 8'hA0 + bus.ss_addr;
    assign bus.mem_ack  = (bus.mem_wr | bus.mem_rd) && (wcnt >= dly);
    assign bus.mem_rdat = mem[bus.mem_addr];
    always @(posedge m2) begin
        wcnt <= ((bus.mem_wr | bus.mem_rd) && !bus.mem_ack) ? wcnt + 1 : 0;
        if (bus.mem_wr && bus.mem_ack) begin
            saved[bus.mem_addr] <= bus.mem_wdat;
            wr_cnt <= wr_cnt + 1;
        end
        if (bus.ss_we) begin
            we_cnt  <= we_cnt + 1;
            we_mask <= we_mask | (16'd1 << bus.ss_addr[3:0]);
            if (bus.ss_addr == 8'd9 || bus.ss_addr > 8'd13 || bus.ss_wdat != (bus.ss_addr ^ 8'h5A))
                bad_we <= bad_we + 1;
        end
        if ((bus.mem_wr && bus.mem_rd) || ((bus.mem_wr || bus.mem_rd) && bus.mem_addr == 8'd10))
            viol <= viol + 1;
        if ((bus.mem_wr || bus.mem_rd) && pend_q && (bus.mem_addr != pa || bus.mem_wdat != pd))
            unstable <= unstable + 1;
        pend_q <= (bus.mem_wr || bus.mem_rd) && !bus.mem_ack;
        pa <= bus.mem_addr;
        pd <= bus.mem_wdat;
    end
    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask
    function automatic logic [63:0] outs();
        return 64'({busy, done, err, bus.ss_act, bus.ss_we, bus.ss_addr, bus.ss_wdat,
                    bus.mem_addr, bus.mem_wr, bus.mem_rd, bus.mem_wdat});
    endfunction
    task automatic start(input logic sv, input logic ld);
        @(negedge m2);
        cmd_save = sv;
        cmd_load = ld;
        @(negedge m2);
        cmd_save = 1'b0;
        cmd_load = 1'b0;
    endtask
    int act_bad = 0;
    task automatic wait_done(input int inj, output int cyc, output int bcnt);
        cyc  = 1;
        bcnt = 0;
        while (!done && cyc < 500) begin
            if (bus.ss_act !== busy) act_bad++;
            if (busy) bcnt++;
            cmd_load = (cyc == inj);
            @(negedge m2);
            cyc++;
        end
        cmd_load = 1'b0;
        chk("done_seen", done, 1);
    endtask
    typedef struct {
        logic       ld;
        int         dl;
        logic [7:0] hdr;
        int         cyc;
        int         we;
        int         wr;
        logic       er;
    } vec_t;
    vec_t vt [6];
    initial begin
        int cyc, bcnt, w0, r0, seen;
        vt[0] = '{1'b0, 0, 8'h00, 29, 0, 14, 1'b0};
        vt[1] = '{1'b0, 3, 8'h00, 71, 0, 14, 1'b0};
        vt[2] = '{1'b1, 0, 8'h31, 29, 13, 0, 1'b0};
        vt[3] = '{1'b1, 0, 8'h32, 3, 0, 0, 1'b1};
        vt[4] = '{1'b0, 1, 8'h00, 43, 0, 14, 1'b0};
        vt[5] = '{1'b1, 1, 8'h31, 43, 13, 0, 1'b0};
        for (int n = 0; n <= 13; n++) mem[1 + n] = 8'(n) ^ 8'h5A;
        mem[10] = 8'hEE;
        repeat (3) @(negedge m2);
        chk("reset_outs", outs(), 0);
        map_rst = 1'b0;
        @(negedge m2);
        chk("idle_outs", outs(), 0);
        for (int i = 0; i < 6; i++) begin
            dly = vt[i].dl;
            mem[0] = vt[i].hdr;
            w0 = we_cnt;
            r0 = wr_cnt;
            start(!vt[i].ld, vt[i].ld);
            chk($sformatf("v%0d_err_clr", i), err, 0);
            chk($sformatf("v%0d_busy1", i), busy, 1);
            wait_done(-1, cyc, bcnt);
            chk($sformatf("v%0d_done_cyc", i), cyc, vt[i].cyc);
            chk($sformatf("v%0d_busy_cyc", i), bcnt, vt[i].cyc - 1);
            chk($sformatf("v%0d_err", i), err, vt[i].er);
            chk($sformatf("v%0d_we", i), we_cnt - w0, vt[i].we);
            chk($sformatf("v%0d_wr", i), wr_cnt - r0, vt[i].wr);
            if (!vt[i].ld) begin
                chk($sformatf("v%0d_buf0", i), saved[0], 8'h31);
                for (int n = 0; n <= 13; n++)
                    if (n != 9) chk($sformatf("v%0d_buf%0d", i, n + 1), saved[n + 1], 8'hA0 + 8'(n));
            end
            @(negedge m2);
            chk($sformatf("v%0d_done_pulse", i), {done, busy}, 0);
        end
        chk("we_mask", we_mask, 16'h3DFF);
        dly = 0;
        start(1'b1, 1'b0);
        repeat (9) @(negedge m2);
        map_rst = 1'b1;
        @(negedge m2);
        map_rst = 1'b0;
        chk("rst_mid_outs", outs(), 0);
        seen = 0;
        repeat (35) begin
            @(negedge m2);
            if (done) seen++;
        end
        chk("rst_no_done", seen, 0);
        mem[0] = 8'h31;
        w0 = we_cnt;
        start(1'b0, 1'b1);
        wait_done(-1, cyc, bcnt);
        chk("rst_load_cyc", cyc, 29);
        chk("rst_load_we", we_cnt - w0, 13);
        w0 = we_cnt;
        r0 = wr_cnt;
        start(1'b1, 1'b1);
        wait_done(-1, cyc, bcnt);
        chk("both_cyc", cyc, 29);
        chk("both_we", we_cnt - w0, 0);
        chk("both_wr", wr_cnt - r0, 14);
        w0 = we_cnt;
        r0 = wr_cnt;
        start(1'b1, 1'b0);
        wait_done(5, cyc, bcnt);
        chk("inj_cyc", cyc, 29);
        chk("inj_we", we_cnt - w0, 0);
        chk("inj_wr", wr_cnt - r0, 14);
        @(negedge m2);
        chk("inj_idle", busy, 0);
        chk("bad_we", bad_we, 0);
        chk("bus_viol", viol, 0);
        chk("unstable", unstable, 0);
        chk("act_busy", act_bad, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
